// File: rtl/vga_timing_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_delay_line
// Description : Delays the complete VGA timing/RGB bundle by a runtime
//               selectable number of pclk cycles (1..DEPTH). A new delay is
//               adopted only on a vblnk rising edge. The colour and blanking
//               outputs are forced blank while the newly selected tap fills
//               with fresh data.
// Ports       : pclk, rst                 - pixel clock, sync active-high reset
//               delay_req                 - requested delay (clamped 1..DEPTH)
//               *_in                      - incoming VGA bundle
//               *_out                     - delayed bundle (masked while filling)
//               delay_cur                 - delay currently in force
//               pipe_valid                - outputs carry real, unmasked data
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_delay_line #(
    parameter int DEPTH         = 4,
    parameter int SEL_W         = 3,
    parameter int CNT_W         = 12,
    parameter int RGB_W         = 12,
    parameter int DEFAULT_DELAY = 1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [SEL_W-1:0] delay_req,
    input  logic [CNT_W-1:0] vcount_in,
    input  logic             vsync_in,
    input  logic             vblnk_in,
    input  logic [CNT_W-1:0] hcount_in,
    input  logic             hsync_in,
    input  logic             hblnk_in,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [CNT_W-1:0] vcount_out,
    output logic             vsync_out,
    output logic             vblnk_out,
    output logic [CNT_W-1:0] hcount_out,
    output logic             hsync_out,
    output logic             hblnk_out,
    output logic [RGB_W-1:0] rgb_out,
    output logic [SEL_W-1:0] delay_cur,
    output logic             pipe_valid
);

    localparam int               c_bundle_w = 2 * CNT_W + RGB_W + 4;
    localparam logic [SEL_W-1:0] c_depth    = SEL_W'(DEPTH);
    localparam logic [SEL_W-1:0] c_default  = SEL_W'(DEFAULT_DELAY);
    localparam logic [SEL_W-1:0] c_one      = SEL_W'(1);

    // Delay-line storage; r_stage[k] holds the bundle seen k cycles ago.
    logic [c_bundle_w-1:0] r_stage [1:DEPTH];

    logic [SEL_W-1:0]      r_delay_cur;
    logic [SEL_W-1:0]      r_fill_cnt;
    logic                  r_vblnk_prev;

    logic [c_bundle_w-1:0] w_in;
    logic [c_bundle_w-1:0] w_tap;
    logic [SEL_W-1:0]      w_req_c;
    logic                  w_boundary;
    logic                  w_filled;

    logic [CNT_W-1:0]      w_tap_vcount;
    logic                  w_tap_vsync;
    logic                  w_tap_vblnk;
    logic [CNT_W-1:0]      w_tap_hcount;
    logic                  w_tap_hsync;
    logic                  w_tap_hblnk;
    logic [RGB_W-1:0]      w_tap_rgb;

    assign w_in = {vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in, rgb_in};

    // ------------------------------------------------------------------
    // Shift register: every stage advances every cycle, no stall.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[1] <= w_in;
            for (int k = 2; k <= DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Request clamp into the legal 1..DEPTH range.
    // ------------------------------------------------------------------
    always_comb begin
        w_req_c = delay_req;
        if (delay_req == '0) begin
            w_req_c = c_one;
        end else if (delay_req > c_depth) begin
            w_req_c = c_depth;
        end
    end

    // Frame boundary is the first cycle of vertical blanking.
    assign w_boundary = vblnk_in & ~r_vblnk_prev;

    // ------------------------------------------------------------------
    // Delay selection and fill counter. The fill counter is loaded with
    // the new delay so the mask lasts until the new tap holds data that
    // entered after the switch.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_delay_cur  <= c_default;
            r_fill_cnt   <= c_default;
            r_vblnk_prev <= 1'b0;
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (w_boundary && (w_req_c != r_delay_cur)) begin
                r_delay_cur <= w_req_c;
                r_fill_cnt  <= w_req_c;
            end else if (r_fill_cnt != '0) begin
                r_fill_cnt <= r_fill_cnt - c_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output tap mux. Out-of-range selects cannot occur (clamped), the
    // zero default only keeps the mux free of latches.
    // ------------------------------------------------------------------
    always_comb begin
        w_tap = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (r_delay_cur == SEL_W'(k)) begin
                w_tap = r_stage[k];
            end
        end
    end

    assign {w_tap_vcount, w_tap_vsync, w_tap_vblnk,
            w_tap_hcount, w_tap_hsync, w_tap_hblnk, w_tap_rgb} = w_tap;

    assign w_filled = (r_fill_cnt == '0);

    // Sync and counters pass unmasked so the display never loses lock;
    // colour and blanking are forced blank while the tap is filling.
    assign vcount_out = w_tap_vcount;
    assign vsync_out  = w_tap_vsync;
    assign hcount_out = w_tap_hcount;
    assign hsync_out  = w_tap_hsync;
    assign vblnk_out  = w_tap_vblnk | ~w_filled;
    assign hblnk_out  = w_tap_hblnk | ~w_filled;
    assign rgb_out    = w_filled ? w_tap_rgb : '0;
    assign delay_cur  = r_delay_cur;
    assign pipe_valid = w_filled;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_delay_line
// Description : Self-checking bench for vga_timing_delay_line (DEPTH=4,
//               DEFAULT_DELAY=2): hand-computed vector table, directed
//               sequences for delay switching, and random traffic compared
//               against a history-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_delay_line;

    localparam int DEPTH  = 4;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 12;
    localparam int RGB_W  = 12;
    localparam int DEF_D  = 2;

    logic             pclk = 1'b0;
    logic             rst;
    logic [SEL_W-1:0] delay_req;
    logic [CNT_W-1:0] vcount_in, hcount_in;
    logic             vsync_in, vblnk_in, hsync_in, hblnk_in;
    logic [RGB_W-1:0] rgb_in;
    logic [CNT_W-1:0] vcount_out, hcount_out;
    logic             vsync_out, vblnk_out, hsync_out, hblnk_out;
    logic [RGB_W-1:0] rgb_out;
    logic [SEL_W-1:0] delay_cur;
    logic             pipe_valid;

    vga_timing_delay_line #(
        .DEPTH(DEPTH), .SEL_W(SEL_W), .CNT_W(CNT_W), .RGB_W(RGB_W),
        .DEFAULT_DELAY(DEF_D)
    ) dut (
        .pclk(pclk), .rst(rst), .delay_req(delay_req),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out), .delay_cur(delay_cur), .pipe_valid(pipe_valid)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [CNT_W-1:0] vc;
        logic             vs;
        logic             vb;
        logic [CNT_W-1:0] hc;
        logic             hs;
        logic             hb;
        logic [RGB_W-1:0] rgb;
    } bundle_t;

    bundle_t hist [1:DEPTH];      // hist[k] = input bundle from k edges ago
    int      m_delay;
    int      m_fill;
    logic    m_vprev;
    logic [RGB_W-1:0] drv_q [$];  // rgb values clocked in, oldest first

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bundle_t cur, input logic r, input int req);
        int  req_c;
        if (r) begin
            for (int k = 1; k <= DEPTH; k++) hist[k] = '0;
            m_delay = DEF_D;
            m_fill  = DEF_D;
            m_vprev = 1'b0;
        end else begin
            req_c = (req == 0) ? 1 : ((req > DEPTH) ? DEPTH : req);
            for (int k = DEPTH; k >= 2; k--) hist[k] = hist[k-1];
            hist[1] = cur;
            if (cur.vb && !m_vprev && req_c != m_delay) begin
                m_delay = req_c;
                m_fill  = req_c;
            end else if (m_fill > 0) begin
                m_fill--;
            end
            m_vprev = cur.vb;
        end
    endtask

    task automatic model_check();
        bundle_t     e;
        logic        masked;
        logic [63:0] act, exp;
        e      = hist[m_delay];
        masked = (m_fill != 0);
        act = {vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out,
               rgb_out, delay_cur, pipe_valid};
        exp = {e.vc, e.vs, e.vb | masked, e.hc, e.hs, e.hb | masked,
               masked ? '0 : e.rgb, SEL_W'(m_delay), ~masked};
        chk("model", act, exp);
    endtask

    // Advance one edge: model sees the inputs present at the edge, DUT is
    // sampled 1 time unit later.
    task automatic tick();
        bundle_t cur;
        logic    r;
        int      req;
        cur = '{vc: vcount_in, vs: vsync_in, vb: vblnk_in, hc: hcount_in,
                hs: hsync_in, hb: hblnk_in, rgb: rgb_in};
        r   = rst;
        req = int'(delay_req);
        @(posedge pclk);
        model_step(cur, r, req);
        if (!r) drv_q.push_back(cur.rgb);
        #1;
        model_check();
    endtask

    logic [RGB_W-1:0] pix = '0;
    task automatic next_pix();
        pix++;
        rgb_in    = pix;
        hcount_in = CNT_W'(pix);
    endtask

    task automatic boundary(input logic [SEL_W-1:0] req);
        vblnk_in = 1'b0; next_pix(); tick();
        delay_req = req; vblnk_in = 1'b1; next_pix(); tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             rst;
        logic [11:0]      val;     // drives hcount_in and rgb_in
        logic [2:0]       e_delay;
        logic             e_valid;
        logic [11:0]      e_rgb;
        logic             e_hblnk;
        logic [11:0]      e_hc;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{1'b1, 12'h000, 3'd2, 1'b0, 12'h000, 1'b1, 12'h000};
        tbl[1] = '{1'b1, 12'h000, 3'd2, 1'b0, 12'h000, 1'b1, 12'h000};
        tbl[2] = '{1'b1, 12'h000, 3'd2, 1'b0, 12'h000, 1'b1, 12'h000};
        tbl[3] = '{1'b0, 12'h001, 3'd2, 1'b0, 12'h000, 1'b1, 12'h000};
        tbl[4] = '{1'b0, 12'h002, 3'd2, 1'b1, 12'h001, 1'b0, 12'h001};
        tbl[5] = '{1'b0, 12'h003, 3'd2, 1'b1, 12'h002, 1'b0, 12'h002};
        tbl[6] = '{1'b0, 12'h004, 3'd2, 1'b1, 12'h003, 1'b0, 12'h003};

        rst = 1'b1; delay_req = 3'd2;
        vcount_in = '0; hcount_in = '0; rgb_in = '0;
        vsync_in = 1'b0; vblnk_in = 1'b0; hsync_in = 1'b0; hblnk_in = 1'b0;
        for (int k = 1; k <= DEPTH; k++) hist[k] = '0;
        m_delay = DEF_D; m_fill = DEF_D; m_vprev = 1'b0;

        // Reset and first-pixel latency
        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst; rgb_in = tbl[i].val; hcount_in = tbl[i].val;
            tick();
            chk("tbl_delay", delay_cur,  tbl[i].e_delay);
            chk("tbl_valid", pipe_valid, tbl[i].e_valid);
            chk("tbl_rgb",   rgb_out,    tbl[i].e_rgb);
            chk("tbl_hblnk", hblnk_out,  tbl[i].e_hblnk);
            chk("tbl_hc",    hcount_out, tbl[i].e_hc);
        end
        pix = 12'h004;

        // Mid-frame request must wait for the vblnk rising edge
        delay_req = 3'd4;
        for (int i = 0; i < 3; i++) begin
            next_pix(); tick();
            chk("hold_delay", delay_cur, 3'd2);
            chk("hold_valid", pipe_valid, 1'b1);
        end
        vblnk_in = 1'b1; next_pix(); tick();
        chk("switch_delay", delay_cur, 3'd4);
        chk("switch_valid", pipe_valid, 1'b0);
        chk("switch_rgb", rgb_out, 12'h000);
        // Sync pulses during the fill must appear at the new latency
        for (int i = 0; i < 3; i++) begin
            hsync_in = (i == 1); vsync_in = (i == 0);
            next_pix(); tick();
            chk("fill_valid", pipe_valid, 1'b0);
            chk("fill_rgb", rgb_out, 12'h000);
            chk("fill_hblnk", hblnk_out, 1'b1);
        end
        hsync_in = 1'b0; vsync_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_pix(); tick();
            chk("lag4_valid", pipe_valid, 1'b1);
            chk("lag4_rgb", rgb_out, drv_q[drv_q.size()-4]);
        end

        // Same-value request: no masking at all
        boundary(3'd4);
        for (int i = 0; i < 4; i++) begin
            next_pix(); tick();
            chk("same_valid", pipe_valid, 1'b1);
        end

        // Clamp low and high
        boundary(3'd0);
        chk("clamp_lo", delay_cur, 3'd1);
        for (int i = 0; i < 3; i++) begin next_pix(); tick(); end
        boundary(3'd7);
        chk("clamp_hi", delay_cur, 3'd4);

        // Reset in the middle of a fill (fill_cnt = 3, delay_cur = 4)
        next_pix(); tick();
        chk("midfill_valid", pipe_valid, 1'b0);
        rst = 1'b1; next_pix(); tick();
        chk("rst_delay", delay_cur, 3'd2);
        chk("rst_valid", pipe_valid, 1'b0);
        chk("rst_rgb", rgb_out, 12'h000);
        chk("rst_hc", hcount_out, 12'h000);
        rst = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) vblnk_in = ~vblnk_in;
            if ($urandom_range(0, 9) == 0)  delay_req = SEL_W'($urandom_range(0, 7));
            vcount_in = CNT_W'($urandom);
            hcount_in = CNT_W'($urandom);
            rgb_in    = RGB_W'($urandom);
            vsync_in  = $urandom_range(0, 1) == 1;
            hsync_in  = $urandom_range(0, 1) == 1;
            hblnk_in  = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
